// File: rtl/alu_sequencer_pkg.sv
// Shared ALU select encodings, sequencer command codes, FSM state codes and the
// per-step control word produced by alu_seq_rom.
package alu_sequencer_pkg;

   localparam logic [1:0] ALU_OP_ADD  = 2'd0;
   localparam logic [1:0] ALU_OP_ROL  = 2'd1;
   localparam logic [1:0] ALU_OP_ROR  = 2'd2;
   localparam logic [1:0] ALU_OP_PASS = 2'd3;

   localparam logic [2:0] ALU_IN0_ACC      = 3'd0;
   localparam logic [2:0] ALU_IN0_ACC_INV  = 3'd1;
   localparam logic [2:0] ALU_IN0_REG      = 3'd2;
   localparam logic [2:0] ALU_IN0_REG_INV  = 3'd3;
   localparam logic [2:0] ALU_IN0_DATA     = 3'd4;
   localparam logic [2:0] ALU_IN0_DATA_INV = 3'd5;

   localparam logic [1:0] ALU_IN1_ACC     = 2'd0;
   localparam logic [1:0] ALU_IN1_REG     = 2'd1;
   localparam logic [1:0] ALU_IN1_ONE     = 2'd2;
   localparam logic [1:0] ALU_IN1_ONE_INV = 2'd3;

   localparam logic [1:0] ALU_CIN_ZERO      = 2'd0;
   localparam logic [1:0] ALU_CIN_ONE       = 2'd1;
   localparam logic [1:0] ALU_CIN_CARRY     = 2'd2;
   localparam logic [1:0] ALU_CIN_CARRY_INV = 2'd3;

   localparam logic [3:0] SEQ_OP_NOP = 4'd0;
   localparam logic [3:0] SEQ_OP_ADD = 4'd1;
   localparam logic [3:0] SEQ_OP_SUB = 4'd2;
   localparam logic [3:0] SEQ_OP_LDM = 4'd3;
   localparam logic [3:0] SEQ_OP_IAC = 4'd4;
   localparam logic [3:0] SEQ_OP_DAC = 4'd5;
   localparam logic [3:0] SEQ_OP_RAL = 4'd6;
   localparam logic [3:0] SEQ_OP_RAR = 4'd7;
   localparam logic [3:0] SEQ_OP_CMA = 4'd8;
   localparam logic [3:0] SEQ_OP_CMC = 4'd9;
   localparam logic [3:0] SEQ_OP_CLB = 4'd10;
   localparam logic [3:0] SEQ_OP_INC = 4'd11;
   localparam logic [3:0] SEQ_OP_XCH = 4'd12;
   localparam logic [3:0] SEQ_OP_STC = 4'd13;
   localparam logic [3:0] SEQ_OP_CLC = 4'd14;
   localparam logic [3:0] SEQ_OP_RSV = 4'd15;

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StExec = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   // All-zero word is the idle value: ADD/ACC/ACC/ZERO, no writes.
   typedef struct packed {
      logic [1:0] alu_op;
      logic [2:0] in0_sel;
      logic [1:0] in1_sel;
      logic [1:0] cin_sel;
      logic       acc_we;
      logic       carry_we;
      logic       reg_we;
      logic       wb_tmp;
      logic       tmp_load;
      logic       last;
   } step_ctrl_t;

endpackage

// File: rtl/alu_seq_rom.sv
// Combinational step table: (command, step index) -> ALU selects, write enables,
// writeback source, temp-latch load and last-step flag.
module alu_seq_rom
   import alu_sequencer_pkg::*;
(
   input  logic [3:0] op_i,
   input  logic [1:0] step_i,
   output step_ctrl_t ctrl_o
);

   always_comb begin
      ctrl_o      = '0;
      ctrl_o.last = 1'b1;
      unique case (op_i)
         SEQ_OP_ADD: begin
            ctrl_o.in0_sel  = ALU_IN0_REG;
            ctrl_o.cin_sel  = ALU_CIN_CARRY;
            ctrl_o.acc_we   = 1'b1;
            ctrl_o.carry_we = 1'b1;
         end
         SEQ_OP_SUB: begin
            ctrl_o.in0_sel  = ALU_IN0_REG_INV;
            ctrl_o.cin_sel  = ALU_CIN_CARRY_INV;
            ctrl_o.acc_we   = 1'b1;
            ctrl_o.carry_we = 1'b1;
         end
         SEQ_OP_LDM: begin
            ctrl_o.in0_sel = ALU_IN0_DATA;
            ctrl_o.cin_sel = ALU_CIN_CARRY;
            ctrl_o.alu_op  = ALU_OP_PASS;
            ctrl_o.acc_we  = 1'b1;
         end
         SEQ_OP_IAC, SEQ_OP_DAC: begin
            ctrl_o.in1_sel  = (op_i == SEQ_OP_IAC) ? ALU_IN1_ONE : ALU_IN1_ONE_INV;
            ctrl_o.cin_sel  = (op_i == SEQ_OP_IAC) ? ALU_CIN_ZERO : ALU_CIN_ONE;
            ctrl_o.acc_we   = 1'b1;
            ctrl_o.carry_we = 1'b1;
         end
         SEQ_OP_RAL, SEQ_OP_RAR: begin
            ctrl_o.cin_sel  = ALU_CIN_CARRY;
            ctrl_o.alu_op   = (op_i == SEQ_OP_RAL) ? ALU_OP_ROL : ALU_OP_ROR;
            ctrl_o.acc_we   = 1'b1;
            ctrl_o.carry_we = 1'b1;
         end
         SEQ_OP_CMA: begin
            ctrl_o.in0_sel = ALU_IN0_ACC_INV;
            ctrl_o.cin_sel = ALU_CIN_CARRY;
            ctrl_o.alu_op  = ALU_OP_PASS;
            ctrl_o.acc_we  = 1'b1;
         end
         SEQ_OP_CMC: begin
            ctrl_o.cin_sel  = ALU_CIN_CARRY_INV;
            ctrl_o.alu_op   = ALU_OP_PASS;
            ctrl_o.carry_we = 1'b1;
         end
         SEQ_OP_CLB: begin
            if (step_i == 2'd0) begin
               // ~acc + acc + 1 wraps to zero, clearing acc in one pass.
               ctrl_o.in0_sel  = ALU_IN0_ACC_INV;
               ctrl_o.cin_sel  = ALU_CIN_ONE;
               ctrl_o.acc_we   = 1'b1;
               ctrl_o.carry_we = 1'b1;
               ctrl_o.last     = 1'b0;
            end else begin
               ctrl_o.alu_op   = ALU_OP_PASS;
               ctrl_o.carry_we = 1'b1;
            end
         end
         SEQ_OP_INC: begin
            ctrl_o.in0_sel = ALU_IN0_REG;
            ctrl_o.in1_sel = ALU_IN1_ONE;
            ctrl_o.reg_we  = 1'b1;
         end
         SEQ_OP_XCH: begin
            unique case (step_i)
               2'd0: begin
                  ctrl_o.in0_sel  = ALU_IN0_REG;
                  ctrl_o.cin_sel  = ALU_CIN_CARRY;
                  ctrl_o.alu_op   = ALU_OP_PASS;
                  ctrl_o.tmp_load = 1'b1;
                  ctrl_o.last     = 1'b0;
               end
               2'd1: begin
                  ctrl_o.cin_sel = ALU_CIN_CARRY;
                  ctrl_o.alu_op  = ALU_OP_PASS;
                  ctrl_o.reg_we  = 1'b1;
                  ctrl_o.last    = 1'b0;
               end
               default: begin
                  ctrl_o.wb_tmp = 1'b1;
                  ctrl_o.acc_we = 1'b1;
               end
            endcase
         end
         SEQ_OP_STC, SEQ_OP_CLC: begin
            ctrl_o.cin_sel  = (op_i == SEQ_OP_STC) ? ALU_CIN_ONE : ALU_CIN_ZERO;
            ctrl_o.alu_op   = ALU_OP_PASS;
            ctrl_o.carry_we = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle accumulator-group controller: FSM, step counter and XCH temp latch.
// Optional sticky illegal-opcode flag when ALU_SEQ_ILLEGAL_TRAP_EN is defined.
module alu_sequencer
   import alu_sequencer_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       start_i,
   input  logic [3:0] op_i,
   output logic       ready_o,
   output logic       busy_o,
   output logic       done_o,
   output logic [1:0] alu_op_o,
   output logic [2:0] alu_in0_sel_o,
   output logic [1:0] alu_in1_sel_o,
   output logic [1:0] alu_cin_sel_o,
   input  logic [4:0] alu_result_i,
   output logic       acc_we_o,
   output logic       carry_we_o,
   output logic       reg_we_o,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   output logic       illegal_o,
`endif
   output logic [3:0] wb_data_o
);

   logic [1:0] state_q, state_d;
   logic [1:0] step_q, step_d;
   logic [3:0] op_q, op_d;
   logic [3:0] tmp_q, tmp_d;
   logic       exec;
   logic       accept;
   step_ctrl_t rom_ctrl;
   step_ctrl_t ctrl;

   alu_seq_rom u_rom (
      .op_i   (op_q),
      .step_i (step_q),
      .ctrl_o (rom_ctrl)
   );

   assign exec    = (state_q == StExec);
   assign ready_o = (state_q == StIdle) || (state_q == StDone);
   assign busy_o  = exec;
   assign done_o  = (state_q == StDone);
   assign accept  = start_i && ready_o;
   assign ctrl    = exec ? rom_ctrl : '0;

   assign alu_op_o      = ctrl.alu_op;
   assign alu_in0_sel_o = ctrl.in0_sel;
   assign alu_in1_sel_o = ctrl.in1_sel;
   assign alu_cin_sel_o = ctrl.cin_sel;
   assign acc_we_o      = ctrl.acc_we;
   assign carry_we_o    = ctrl.carry_we;
   assign reg_we_o      = ctrl.reg_we;
   assign wb_data_o     = ctrl.wb_tmp ? tmp_q : alu_result_i[3:0];

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      op_d    = op_q;
      tmp_d   = ctrl.tmp_load ? alu_result_i[3:0] : tmp_q;
      if (accept) begin
         state_d = StExec;
         step_d  = 2'd0;
         op_d    = op_i;
      end else if (exec) begin
         if (rom_ctrl.last) begin
            state_d = StDone;
         end else begin
            step_d = step_q + 2'd1;
         end
      end else if (state_q == StDone) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         step_q  <= 2'd0;
         op_q    <= SEQ_OP_NOP;
         tmp_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         op_q    <= op_d;
         tmp_q   <= tmp_d;
      end
   end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         illegal_q <= 1'b0;
      end else if (accept && (op_i == SEQ_OP_RSV)) begin
         illegal_q <= 1'b1;
      end
   end

   assign illegal_o = illegal_q;
`endif

endmodule
